uart_echo_responder: RTL and testbench
======================================

UART_ECHO_RESPONDER -- requirements
Module: uart_echo_responder

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, meaning number of buffered bytes; SHALL be a power of two, 4 to 256.
REQ-002 Parameter CRLF_EXPAND, default 1, meaning 1 = each echoed 0x0D is followed by an inserted 0x0A.
REQ-003 Port i_clk  input  1  sole clock, all logic rising-edge.
REQ-004 Port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port i_rx_byte_rdy  input  1  one-cycle strobe, i_rx_byte valid this cycle.
REQ-006 Port i_rx_byte  input  8  received byte.
REQ-007 Port i_tx_busy  input  1  transmitter busy.
REQ-008 Port o_tx_byte_rdy  output  1  one-cycle strobe requesting transmission of o_tx_byte.
REQ-009 Port o_tx_byte  output  8  byte to transmit; held stable from strobe until i_tx_busy falls.
REQ-010 Port i_clr_ovf  input  1  clears o_overflow.
REQ-011 Port o_overflow  output  1  sticky flag, byte dropped on full FIFO.
REQ-012 Port o_fifo_count  output  clog2(FIFO_DEPTH)+1  bytes currently buffered.

Function
REQ-013 Every i_rx_byte_rdy strobe SHALL push i_rx_byte into the FIFO at that clock edge, unless the push is rejected under REQ-014.
REQ-014 Push when full with no pop in the same cycle SHALL drop the byte, leave FIFO unchanged, and set o_overflow.
REQ-015 Push and pop in the same cycle SHALL both take effect, including when full; count unchanged, no overflow.
REQ-016 Read and write pointers SHALL wrap modulo FIFO_DEPTH; full/empty derive from o_fifo_count (0 = empty, FIFO_DEPTH = full).
REQ-017 FSM states: IDLE, ISSUE, WAIT_HI, WAIT_LO, ISSUE_LF.
REQ-018 IDLE -> ISSUE when FIFO non-empty and i_tx_busy = 0; transition pops head into o_tx_byte.
REQ-019 ISSUE: o_tx_byte_rdy = 1 for exactly one cycle -> WAIT_HI.
REQ-020 WAIT_HI: stay until i_tx_busy = 1 -> WAIT_LO; i_tx_busy is guaranteed to rise within 2 cycles of the strobe.
REQ-021 WAIT_LO: stay until i_tx_busy = 0; then -> ISSUE_LF if CRLF_EXPAND = 1, the last byte was 0x0D, and no LF has yet been sent for it; else -> IDLE.
REQ-022 ISSUE_LF: o_tx_byte = 0x0A, o_tx_byte_rdy = 1 for one cycle -> WAIT_HI; the LF is not re-expanded.
REQ-023 Latency: with FSM in IDLE, FIFO empty, and i_tx_busy = 0, a strobe in cycle 0 SHALL yield o_tx_byte_rdy = 1 in cycle 2.
REQ-024 o_tx_byte_rdy SHALL never be asserted while i_tx_busy = 1 or in two consecutive cycles.
REQ-025 i_clr_ovf SHALL clear o_overflow next edge; a simultaneous overflow event SHALL win (flag stays 1).
REQ-026 Bytes SHALL be echoed in arrival order; none lost except by REQ-014.

Reset
REQ-027 i_rst_n low SHALL immediately force: FSM = IDLE, pointers = 0, o_fifo_count = 0, o_tx_byte_rdy = 0, o_tx_byte = 0x00, o_overflow = 0.
REQ-028 Reset mid-transmission SHALL discard buffered bytes and any pending LF; no strobe in the first cycle after release.
REQ-029 FIFO storage array SHALL not require reset.

Structure
REQ-030 Shared package uart_pkg SHALL hold the FSM state encoding and constants ASCII_CR = 0x0D and ASCII_LF = 0x0A.
REQ-031 FIFO SHALL be a separate sub-module byte_fifo (parameter DEPTH; push, pop, data in/out, count, full, empty).
REQ-032 uart_echo_responder SHALL connect directly to the uart byte interface for loopback with no glue logic.

Verification
REQ-033 Idle, empty FIFO; strobe 0x41 in cycle 0 -> o_tx_byte_rdy in cycle 2 with o_tx_byte = 0x41; count returns to 0.
REQ-034 Strobe 0x0D, CRLF_EXPAND = 1 -> two strobes: 0x0D, then 0x0A after busy falls; with CRLF_EXPAND = 0 -> only 0x0D.
REQ-035 Hold i_tx_busy = 1; push 17 bytes into depth 16 -> count = 16, o_overflow = 1, byte 17 dropped; release busy -> bytes 1..16 echoed in order.
REQ-036 FIFO full, push and pop in the same cycle -> count stays 16, o_overflow stays 0, new byte echoed last.
REQ-037 Assert i_rst_n low during WAIT_LO with 5 bytes queued -> all outputs at reset values immediately; no echo after release.
REQ-038 i_clr_ovf and overflow event in the same cycle -> o_overflow = 1; i_clr_ovf alone next cycle -> 0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: echo responder FSM encoding and ASCII constants
package uart_pkg;
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ISSUE    = 3'd1;
  localparam logic [2:0] ST_WAIT_HI  = 3'd2;
  localparam logic [2:0] ST_WAIT_LO  = 3'd3;
  localparam logic [2:0] ST_ISSUE_LF = 3'd4;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: power-of-two byte FIFO; a push on full is accepted only alongside a pop
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               wr_data,
  output logic [7:0]               rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr_en, rd_en;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign rd_en   = pop && !empty;
  assign wr_en   = push && (!full || rd_en);
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
endmodule

// File: rtl/uart_echo_responder.sv
// uart_echo_responder: buffers received bytes and echoes them to the transmitter,
// optionally following every echoed CR with an inserted LF
module uart_echo_responder
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int CRLF_EXPAND = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_rx_byte_rdy,
  input  logic [7:0]                   i_rx_byte,
  input  logic                         i_tx_busy,
  output logic                         o_tx_byte_rdy,
  output logic [7:0]                   o_tx_byte,
  input  logic                         i_clr_ovf,
  output logic                         o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]  o_fifo_count
);
  logic [2:0] state;
  logic [7:0] head;
  logic full, empty, pop, drop;
  assign pop           = state == ST_IDLE && !empty && !i_tx_busy;
  assign drop          = i_rx_byte_rdy && full && !pop;
  assign o_tx_byte_rdy = state == ST_ISSUE || state == ST_ISSUE_LF;
  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .push    (i_rx_byte_rdy),
    .pop     (pop),
    .wr_data (i_rx_byte),
    .rd_data (head),
    .count   (o_fifo_count),
    .full    (full),
    .empty   (empty)
  );
  // o_tx_byte doubles as the "last byte sent" record; once it holds LF no further expansion occurs
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      o_tx_byte <= 8'h00;
    end else begin
      case (state)
        ST_IDLE:
          if (pop) begin
            state     <= ST_ISSUE;
            o_tx_byte <= head;
          end
        ST_ISSUE:    state <= ST_WAIT_HI;
        ST_WAIT_HI:  if (i_tx_busy) state <= ST_WAIT_LO;
        ST_WAIT_LO:
          if (!i_tx_busy) begin
            if (CRLF_EXPAND != 0 && o_tx_byte == ASCII_CR) begin
              state     <= ST_ISSUE_LF;
              o_tx_byte <= ASCII_LF;
            end else begin
              state <= ST_IDLE;
            end
          end
        ST_ISSUE_LF: state <= ST_WAIT_HI;
        default:     state <= ST_IDLE;
      endcase
    end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) o_overflow <= 1'b0;
    else if (drop) o_overflow <= 1'b1;
    else if (i_clr_ovf) o_overflow <= 1'b0;
endmodule

// File: tb/tb_uart_echo_responder.sv
// tb_uart_echo_responder: randomized echo checks against a queue model of the expected byte stream
module tb_uart_echo_responder;
  localparam int DEPTH = 16;
  logic clk = 0, rst_n = 0, rx_rdy = 0, clr = 0, hold = 0, tx_busy = 0;
  logic [7:0] rx_byte = 0;
  logic busy;
  logic tx_rdy, tx_rdy1, ovf, ovf1;
  logic [7:0] tx_byte, tx_byte1;
  logic [4:0] count, count1;
  int compared = 0, mismatched = 0;
  logic [7:0] got[$], got1[$], exp[$];
  int busy_left = 0;
  bit arm = 0, prev_rdy = 0;
  assign busy = tx_busy | hold;
  always #5 clk = ~clk;
  uart_echo_responder #(.FIFO_DEPTH(DEPTH), .CRLF_EXPAND(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_byte_rdy(rx_rdy), .i_rx_byte(rx_byte),
    .i_tx_busy(busy), .o_tx_byte_rdy(tx_rdy), .o_tx_byte(tx_byte),
    .i_clr_ovf(clr), .o_overflow(ovf), .o_fifo_count(count));
  uart_echo_responder #(.FIFO_DEPTH(DEPTH), .CRLF_EXPAND(0)) dut_nolf (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_byte_rdy(rx_rdy), .i_rx_byte(rx_byte),
    .i_tx_busy(busy), .o_tx_byte_rdy(tx_rdy1), .o_tx_byte(tx_byte1),
    .i_clr_ovf(clr), .o_overflow(ovf1), .o_fifo_count(count1));
  // transmitter model: busy rises the cycle after a strobe and stays up 1..4 cycles
  always @(negedge clk) begin
    if (!rst_n) begin
      tx_busy = 0; busy_left = 0; arm = 0; prev_rdy = 0;
    end else begin
      if (tx_rdy1) got1.push_back(tx_byte1);
      if (tx_rdy) begin
        compared++;
        if (busy !== 1'b0 || prev_rdy) begin
          mismatched++;
          $display("FAIL strobe_protocol: busy=%b prev_strobe=%b, required busy=0 prev_strobe=0", busy, prev_rdy);
        end
        got.push_back(tx_byte);
        arm = 1;
      end else if (arm) begin
        arm = 0; tx_busy = 1; busy_left = $urandom_range(1, 4);
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) tx_busy = 0;
      end
      prev_rdy = tx_rdy;
    end
  end
  function automatic void add_exp(input logic [7:0] b);
    exp.push_back(b);
    if (b == 8'h0D) exp.push_back(8'h0A);
  endfunction
  task automatic wait_drain(input string name);
    int quiet = 0, n = 0;
    while (quiet < 10 && n < 2000) begin
      @(negedge clk);
      n++;
      quiet = (count == 0 && !busy && !tx_rdy && !arm) ? quiet + 1 : 0;
    end
    if (quiet < 10) begin
      compared++; mismatched++;
      $display("FAIL %s_drain: count=%0d, required 0 within cycle budget", name, count);
    end
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    compared++;
    if (tx_rdy !== 1'b0 || tx_byte !== 8'h00 || ovf !== 1'b0 || count !== 5'd0) begin
      mismatched++;
      $display("FAIL reset_state: rdy=%b byte=%h ovf=%b count=%0d, required 0/00/0/0", tx_rdy, tx_byte, ovf, count);
    end
    #2 rst_n = 1;
    repeat (2) begin
      @(negedge clk);
      compared++;
      if (tx_rdy !== 1'b0 || count !== 5'd0) begin
        mismatched++;
        $display("FAIL reset_release: rdy=%b count=%0d, required 0/0", tx_rdy, count);
      end
    end
  endtask
  task automatic test_latency;
    got.delete();
    @(negedge clk); rx_rdy = 1; rx_byte = 8'h41;
    @(negedge clk); rx_rdy = 0;
    compared++;
    if (tx_rdy !== 1'b0 || count !== 5'd1) begin
      mismatched++;
      $display("FAIL latency_cycle1: rdy=%b count=%0d, required 0/1", tx_rdy, count);
    end
    @(negedge clk);
    compared++;
    if (tx_rdy !== 1'b1 || tx_byte !== 8'h41) begin
      mismatched++;
      $display("FAIL latency_cycle2: rdy=%b byte=%h, required 1/41", tx_rdy, tx_byte);
    end
    wait_drain("latency");
    compared++;
    if (count !== 5'd0 || got.size() != 1) begin
      mismatched++;
      $display("FAIL latency_done: count=%0d echoed=%0d, required 0/1", count, got.size());
    end
  endtask
  task automatic test_crlf;
    got.delete(); got1.delete();
    @(negedge clk); rx_rdy = 1; rx_byte = 8'h0D;
    @(negedge clk); rx_rdy = 0;
    wait_drain("crlf");
    compared++;
    if (got.size() != 2 || got[0] !== 8'h0D || got[1] !== 8'h0A) begin
      mismatched++;
      $display("FAIL crlf_expand: echoed %0d bytes first=%h, required 2 bytes 0d 0a", got.size(), got.size() ? got[0] : 8'hxx);
    end
    compared++;
    if (got1.size() != 1 || got1[0] !== 8'h0D || ovf1 !== 1'b0 || count1 !== 5'd0) begin
      mismatched++;
      $display("FAIL crlf_off: echoed %0d bytes ovf=%b count=%0d, required 1 byte 0d ovf 0 count 0", got1.size(), ovf1, count1);
    end
  endtask
  task automatic test_overflow;
    logic [7:0] b;
    got.delete(); exp.delete();
    hold = 1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i == 16) begin
        compared++;
        if (count !== 5'd16 || ovf !== 1'b0) begin
          mismatched++;
          $display("FAIL overflow_full: count=%0d ovf=%b, required 16/0", count, ovf);
        end
      end
      b = 8'($urandom);
      rx_rdy = 1; rx_byte = b;
      if (i < 16) add_exp(b);
    end
    @(negedge clk); rx_rdy = 0;
    compared++;
    if (count !== 5'd16 || ovf !== 1'b1) begin
      mismatched++;
      $display("FAIL overflow_drop: count=%0d ovf=%b, required 16/1", count, ovf);
    end
    hold = 0;
    wait_drain("overflow");
    compared++;
    if (got.size() != exp.size()) begin
      mismatched++;
      $display("FAIL overflow_len: echoed %0d, required %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      compared++;
      if (got[i] !== exp[i]) begin
        mismatched++;
        $display("FAIL overflow_order[%0d]: got %h, required %h", i, got[i], exp[i]);
      end
    end
  endtask
  task automatic test_clr_ovf;
    @(negedge clk); clr = 1;
    @(negedge clk); clr = 0;
    compared++;
    if (ovf !== 1'b0) begin
      mismatched++;
      $display("FAIL clr_alone_initial: ovf=%b, required 0", ovf);
    end
    got.delete();
    hold = 1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); rx_rdy = 1; rx_byte = 8'($urandom_range(32, 126));
    end
    @(negedge clk); rx_byte = 8'h7E; clr = 1;
    @(negedge clk); rx_rdy = 0; clr = 0;
    compared++;
    if (ovf !== 1'b1 || count !== 5'd16) begin
      mismatched++;
      $display("FAIL clr_vs_overflow: ovf=%b count=%0d, required 1/16", ovf, count);
    end
    @(negedge clk); clr = 1;
    @(negedge clk); clr = 0;
    compared++;
    if (ovf !== 1'b0) begin
      mismatched++;
      $display("FAIL clr_alone: ovf=%b, required 0", ovf);
    end
    hold = 0;
    wait_drain("clr_ovf");
    compared++;
    if (got.size() != 16) begin
      mismatched++;
      $display("FAIL clr_ovf_len: echoed %0d, required 16", got.size());
    end
  endtask
  task automatic test_full_push_pop;
    logic [7:0] b;
    got.delete(); exp.delete();
    hold = 1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      b = 8'($urandom);
      rx_rdy = 1; rx_byte = b; add_exp(b);
    end
    @(negedge clk);
    b = 8'($urandom);
    hold = 0; rx_rdy = 1; rx_byte = b; add_exp(b);
    @(negedge clk); rx_rdy = 0;
    compared++;
    if (count !== 5'd16 || ovf !== 1'b0) begin
      mismatched++;
      $display("FAIL full_push_pop: count=%0d ovf=%b, required 16/0", count, ovf);
    end
    wait_drain("full_push_pop");
    compared++;
    if (got.size() != exp.size()) begin
      mismatched++;
      $display("FAIL full_push_pop_len: echoed %0d, required %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      compared++;
      if (got[i] !== exp[i]) begin
        mismatched++;
        $display("FAIL full_push_pop_order[%0d]: got %h, required %h", i, got[i], exp[i]);
      end
    end
  endtask
  task automatic test_random;
    logic [7:0] b;
    for (int r = 0; r < 4; r++) begin
      got.delete(); exp.delete();
      for (int i = 0; i < int'($urandom_range(3, 12)); i++) begin
        @(negedge clk);
        b = ($urandom_range(0, 3) == 0) ? 8'h0D : 8'($urandom);
        rx_rdy = 1; rx_byte = b; add_exp(b);
        if ($urandom_range(0, 1) == 1) begin
          @(negedge clk); rx_rdy = 0;
          repeat ($urandom_range(0, 4)) @(negedge clk);
        end
      end
      @(negedge clk); rx_rdy = 0;
      wait_drain("random");
      compared++;
      if (got.size() != exp.size() || ovf !== 1'b0) begin
        mismatched++;
        $display("FAIL random_len[%0d]: echoed %0d ovf=%b, required %0d ovf=0", r, got.size(), ovf, exp.size());
      end
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
        compared++;
        if (got[i] !== exp[i]) begin
          mismatched++;
          $display("FAIL random_order[%0d][%0d]: got %h, required %h", r, i, got[i], exp[i]);
        end
      end
    end
  endtask
  task automatic test_reset_mid;
    int n = 0;
    @(negedge clk); rx_rdy = 1; rx_byte = 8'h55;
    @(negedge clk); rx_rdy = 0;
    while (!tx_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk); hold = 1;
    for (int i = 0; i < 5; i++) begin
      rx_rdy = 1; rx_byte = 8'($urandom);
      @(negedge clk);
    end
    rx_rdy = 0;
    compared++;
    if (count !== 5'd5 || tx_byte !== 8'h55) begin
      mismatched++;
      $display("FAIL reset_mid_setup: count=%0d byte=%h, required 5/55", count, tx_byte);
    end
    #2 rst_n = 0;
    #1;
    compared++;
    if (tx_rdy !== 1'b0 || tx_byte !== 8'h00 || ovf !== 1'b0 || count !== 5'd0) begin
      mismatched++;
      $display("FAIL reset_mid_async: rdy=%b byte=%h ovf=%b count=%0d, required 0/00/0/0", tx_rdy, tx_byte, ovf, count);
    end
    repeat (2) @(negedge clk);
    #2 rst_n = 1; hold = 0;
    got.delete();
    @(negedge clk);
    compared++;
    if (tx_rdy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mid_first_cycle: rdy=%b, required 0", tx_rdy);
    end
    repeat (30) @(negedge clk);
    compared++;
    if (got.size() != 0 || count !== 5'd0) begin
      mismatched++;
      $display("FAIL reset_mid_no_echo: echoed %0d count=%0d, required 0/0", got.size(), count);
    end
  endtask
  initial begin
    test_reset;
    test_latency;
    test_crlf;
    test_overflow;
    test_clr_ovf;
    test_full_push_pop;
    test_random;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
